// File: rtl/spi_ctrl_tx.sv
`default_nettype none
// ============================================================================
// Module   : spi_ctrl_tx
// Purpose  : SPI master that sends one 16-bit register frame {wr, addr, wdata}
//            per start request.  Phases: LEAD (cs_n low, sclk idle), SHIFT
//            (16 sclk pulses, high half first), TRAIL (cs_n low, sclk idle),
//            GAP (cs_n high).  The last GAP cycle is the done cycle, so a
//            start issued there chains the next frame with exactly CS_GAP
//            cs_n-high cycles between frames.
// Params   : CLK_DIV  clk cycles per sclk half-period (2..255)
//            CS_GAP   clk cycles cs_n high after a frame (1..255)
// Ports    : clk, rst (sync, active-high)
//            start, wr, addr[6:0], wdata[7:0]   frame request
//            sdi                                 MISO
//            sclk, cs_n, sdo                     SPI pins (all registered)
//            busy, done, rdata[15:0]             status / readback
// Option   : SPI_CTRL_TX_READBACK_EN - when defined, sdi is shifted in on
//            every sclk falling edge and published on rdata in the done
//            cycle; otherwise rdata is tied to zero.
// Revision : 1.0 - initial release
// ============================================================================
module spi_ctrl_tx #(
    parameter int CLK_DIV = 4,
    parameter int CS_GAP  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        wr,
    input  logic [6:0]  addr,
    input  logic [7:0]  wdata,
    input  logic        sdi,
    output logic        sclk,
    output logic        cs_n,
    output logic        sdo,
    output logic        busy,
    output logic        done,
    output logic [15:0] rdata
);

    localparam logic [7:0] c_DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [7:0] c_GAP_LAST = 8'(CS_GAP - 1);
    localparam logic [4:0] c_BITS     = 5'd16;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEAD  = 3'd1,
        S_SHIFT = 3'd2,
        S_TRAIL = 3'd3,
        S_GAP   = 3'd4
    } state_t;

    state_t      r_state_q, w_state_d;
    logic [7:0]  r_cnt_q,   w_cnt_d;
    logic [4:0]  r_bit_q,   w_bit_d;
    logic [15:0] r_sr_q,    w_sr_d;
    logic        r_sclk_q,  w_sclk_d;
    logic        r_cs_n_q,  w_cs_n_d;
    logic        r_sdo_q,   w_sdo_d;
    logic        r_busy_q,  w_busy_d;
    logic        r_done_q,  w_done_d;
    logic        w_load;

`ifdef SPI_CTRL_TX_READBACK_EN
    logic [15:0] r_rx_q,    w_rx_d;
    logic [15:0] r_rdata_q, w_rdata_d;
`endif

    always_comb begin
        w_state_d = r_state_q;
        w_cnt_d   = r_cnt_q;
        w_bit_d   = r_bit_q;
        w_sr_d    = r_sr_q;
        w_sclk_d  = r_sclk_q;
        w_sdo_d   = r_sdo_q;
        w_load    = 1'b0;
`ifdef SPI_CTRL_TX_READBACK_EN
        w_rx_d    = r_rx_q;
`endif

        case (r_state_q)
            S_IDLE: begin
                w_load = start && !r_busy_q;
            end
            S_LEAD: begin
                if (r_cnt_q == c_DIV_LAST) begin
                    w_state_d = S_SHIFT;
                    w_cnt_d   = 8'd0;
                    w_sclk_d  = 1'b1;
                    w_sdo_d   = r_sr_q[15];
                end else begin
                    w_cnt_d = r_cnt_q + 8'd1;
                end
            end
            S_SHIFT: begin
                if (r_cnt_q == c_DIV_LAST) begin
                    w_cnt_d = 8'd0;
                    if (r_sclk_q) begin
                        // Falling edge: peripheral samples sdo now; move
                        // the next bit up but keep sdo until the next rise.
                        w_sclk_d = 1'b0;
                        w_bit_d  = r_bit_q + 5'd1;
                        w_sr_d   = {r_sr_q[14:0], 1'b0};
`ifdef SPI_CTRL_TX_READBACK_EN
                        w_rx_d   = {r_rx_q[14:0], sdi};
`endif
                    end else if (r_bit_q == c_BITS) begin
                        // Low half of the 16th pulse is over.
                        w_state_d = S_TRAIL;
                        w_sdo_d   = 1'b0;
                    end else begin
                        w_sclk_d = 1'b1;
                        w_sdo_d  = r_sr_q[15];
                    end
                end else begin
                    w_cnt_d = r_cnt_q + 8'd1;
                end
            end
            S_TRAIL: begin
                if (r_cnt_q == c_DIV_LAST) begin
                    w_state_d = S_GAP;
                    w_cnt_d   = 8'd0;
                end else begin
                    w_cnt_d = r_cnt_q + 8'd1;
                end
            end
            S_GAP: begin
                // The last GAP cycle is the done cycle (busy already low),
                // so a start seen here goes straight into the next LEAD.
                if (r_cnt_q == c_GAP_LAST) begin
                    w_state_d = S_IDLE;
                    w_load    = start && !r_busy_q;
                end else begin
                    w_cnt_d = r_cnt_q + 8'd1;
                end
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase

        if (w_load) begin
            w_state_d = S_LEAD;
            w_cnt_d   = 8'd0;
            w_bit_d   = 5'd0;
            w_sr_d    = {wr, addr, wdata};
`ifdef SPI_CTRL_TX_READBACK_EN
            w_rx_d    = 16'd0;
`endif
        end

        // Status and pins are derived from the next state so they are
        // registered yet aligned with the state they describe.
        w_done_d = (w_state_d == S_GAP) && (w_cnt_d == c_GAP_LAST);
        w_busy_d = (w_state_d != S_IDLE) && !w_done_d;
        w_cs_n_d = !((w_state_d == S_LEAD) || (w_state_d == S_SHIFT) ||
                     (w_state_d == S_TRAIL));
`ifdef SPI_CTRL_TX_READBACK_EN
        w_rdata_d = w_done_d ? r_rx_q : r_rdata_q;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state_q <= S_IDLE;
            r_cnt_q   <= 8'd0;
            r_bit_q   <= 5'd0;
            r_sr_q    <= 16'd0;
            r_sclk_q  <= 1'b0;
            r_cs_n_q  <= 1'b1;
            r_sdo_q   <= 1'b0;
            r_busy_q  <= 1'b0;
            r_done_q  <= 1'b0;
`ifdef SPI_CTRL_TX_READBACK_EN
            r_rx_q    <= 16'd0;
            r_rdata_q <= 16'd0;
`endif
        end else begin
            r_state_q <= w_state_d;
            r_cnt_q   <= w_cnt_d;
            r_bit_q   <= w_bit_d;
            r_sr_q    <= w_sr_d;
            r_sclk_q  <= w_sclk_d;
            r_cs_n_q  <= w_cs_n_d;
            r_sdo_q   <= w_sdo_d;
            r_busy_q  <= w_busy_d;
            r_done_q  <= w_done_d;
`ifdef SPI_CTRL_TX_READBACK_EN
            r_rx_q    <= w_rx_d;
            r_rdata_q <= w_rdata_d;
`endif
        end
    end

    assign sclk = r_sclk_q;
    assign cs_n = r_cs_n_q;
    assign sdo  = r_sdo_q;
    assign busy = r_busy_q;
    assign done = r_done_q;

`ifdef SPI_CTRL_TX_READBACK_EN
    assign rdata = r_rdata_q;
`else
    logic w_unused_sdi;
    assign w_unused_sdi = sdi;
    assign rdata        = 16'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_spi_ctrl_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_ctrl_tx
// Purpose  : Directed self-checking bench for spi_ctrl_tx.  DUT A uses the
//            default parameters and talks to a peripheral model returning
//            0xBEEF; DUT B uses CLK_DIV=2, CS_GAP=1.  Cycle 0 is the cycle
//            in which start is driven high.
// Option   : SPI_CTRL_TX_READBACK_EN selects the expected rdata value.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_ctrl_tx;

`ifdef SPI_CTRL_TX_READBACK_EN
    localparam logic [15:0] c_RD_EXP = 16'hBEEF;
`else
    localparam logic [15:0] c_RD_EXP = 16'h0000;
`endif

    logic        clk = 1'b0;
    logic        rst, start_a, start_b, wr, sdi, sdi_b;
    logic [6:0]  addr;
    logic [7:0]  wdata;
    logic        a_sclk, a_cs_n, a_sdo, a_busy, a_done;
    logic        b_sclk, b_cs_n, b_sdo, b_busy, b_done;
    logic [15:0] a_rdata, b_rdata;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    spi_ctrl_tx u_dut_a (
        .clk(clk), .rst(rst), .start(start_a), .wr(wr), .addr(addr),
        .wdata(wdata), .sdi(sdi), .sclk(a_sclk), .cs_n(a_cs_n), .sdo(a_sdo),
        .busy(a_busy), .done(a_done), .rdata(a_rdata)
    );

    spi_ctrl_tx #(.CLK_DIV(2), .CS_GAP(1)) u_dut_b (
        .clk(clk), .rst(rst), .start(start_b), .wr(wr), .addr(addr),
        .wdata(wdata), .sdi(sdi_b), .sclk(b_sclk), .cs_n(b_cs_n), .sdo(b_sdo),
        .busy(b_busy), .done(b_done), .rdata(b_rdata)
    );

    // Peripheral model on DUT A: shifts 0xBEEF out MSB first, changing MISO
    // on sclk rising edges so it is stable at the falling edge.
    logic [15:0] per_sr = 16'hBEEF;
    always @(negedge a_cs_n) per_sr = 16'hBEEF;
    always @(posedge a_sclk) begin
        sdi    = per_sr[15];
        per_sr = {per_sr[14:0], 1'b0};
    end

    // Observation mux so one frame recorder serves both DUTs.
    int          sel = 0;
    logic        m_sclk, m_cs_n, m_sdo, m_busy, m_done;
    logic [15:0] m_rdata;
    always_comb begin
        m_sclk  = (sel == 1) ? b_sclk  : a_sclk;
        m_cs_n  = (sel == 1) ? b_cs_n  : a_cs_n;
        m_sdo   = (sel == 1) ? b_sdo   : a_sdo;
        m_busy  = (sel == 1) ? b_busy  : a_busy;
        m_done  = (sel == 1) ? b_done  : a_done;
        m_rdata = (sel == 1) ? b_rdata : a_rdata;
    end

    // Frame recorder results.
    int          f_done_cyc, f_rise, f_fall, f_gap, f_rise1, f_rise2;
    int          f_bad_sdo, f_bad_busy;
    logic        f_cs1;
    logic [15:0] f_bits, f_rd, f_rd_pre;

    // Records one frame from cycle 0 (start already driven by the caller)
    // up to and including the done cycle.  Start is re-pulsed at cycles
    // ig0..ig2 and the frame inputs are scrambled at cycle 2.
    task automatic capture(input int ig0, input int ig1, input int ig2);
        logic ps, psdo, s;
        int   n;
        ps = m_sclk; psdo = m_sdo; n = 0;
        f_done_cyc = -1; f_rise = 0; f_fall = 0; f_gap = 0;
        f_rise1 = -1; f_rise2 = -1; f_bad_sdo = 0; f_bad_busy = 0;
        f_cs1 = 1'bx; f_bits = 16'd0; f_rd = 16'hxxxx; f_rd_pre = m_rdata;
        while (n < 1000 && f_done_cyc < 0) begin
            @(negedge clk);
            n++;
            s = (n == ig0) || (n == ig1) || (n == ig2);
            start_a = (sel == 0) ? s : 1'b0;
            start_b = (sel == 1) ? s : 1'b0;
            if (n == 2) begin
                wr = ~wr; addr = ~addr; wdata = ~wdata;
            end
            if (n == 1) f_cs1 = m_cs_n;
            if (!ps && m_sclk) begin
                f_rise++;
                if (f_rise1 < 0) f_rise1 = n;
                else if (f_rise2 < 0) f_rise2 = n;
            end
            if (ps && !m_sclk) begin
                f_fall++;
                f_bits = {f_bits[14:0], m_sdo};
            end
            if ((m_sdo !== psdo) && !(!ps && m_sclk) && f_fall < 16) f_bad_sdo++;
            if (m_cs_n && m_sdo) f_bad_sdo++;
            if (m_cs_n === 1'b1 && n > 1) f_gap++;
            if (m_done === 1'b1) begin
                f_done_cyc = n;
                f_rd = m_rdata;
                if (m_busy !== 1'b0) f_bad_busy++;
            end else begin
                f_rd_pre = m_rdata;
                if (m_busy !== 1'b1) f_bad_busy++;
            end
            ps = m_sclk; psdo = m_sdo;
        end
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start_a = 1'b1; start_b = 1'b1;
        wr = 1'b1; addr = 7'h03; wdata = 8'hA5;
        repeat (3) @(negedge clk);
        tests++;
        if ({a_cs_n, a_sclk, a_sdo, a_busy, a_done} !== 5'b10000) begin
            fails++;
            $display("FAIL reset_pins_a: got %b expected 10000", {a_cs_n, a_sclk, a_sdo, a_busy, a_done});
        end
        tests++;
        if ({b_cs_n, b_sclk, b_sdo, b_busy, b_done} !== 5'b10000) begin
            fails++;
            $display("FAIL reset_pins_b: got %b expected 10000", {b_cs_n, b_sclk, b_sdo, b_busy, b_done});
        end
        tests++;
        if (a_rdata !== 16'h0000) begin
            fails++;
            $display("FAIL reset_rdata: got %h expected 0000", a_rdata);
        end
        rst = 1'b0; start_a = 1'b0; start_b = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if ({a_cs_n, a_busy} !== 2'b10) begin
            fails++;
            $display("FAIL reset_dominates_start: got cs_n,busy=%b expected 10", {a_cs_n, a_busy});
        end
    endtask

    task automatic test_frame();
        sel = 0;
        @(negedge clk);
        wr = 1'b1; addr = 7'h03; wdata = 8'hA5; start_a = 1'b1;
        capture(-1, -1, -1);
        tests++;
        if (f_cs1 !== 1'b0) begin fails++; $display("FAIL frame_cs_low_c1: got %b expected 0", f_cs1); end
        tests++;
        if (f_bits !== 16'h83A5) begin fails++; $display("FAIL frame_bits: got %h expected 83a5", f_bits); end
        tests++;
        if (f_done_cyc != 140) begin fails++; $display("FAIL frame_done_cycle: got %0d expected 140", f_done_cyc); end
        tests++;
        if (f_rise != 16 || f_fall != 16) begin
            fails++; $display("FAIL frame_pulses: got rise=%0d fall=%0d expected 16/16", f_rise, f_fall);
        end
        tests++;
        if (f_rise1 != 5 || f_rise2 != 13) begin
            fails++; $display("FAIL frame_sclk_timing: got rises at %0d,%0d expected 5,13", f_rise1, f_rise2);
        end
        tests++;
        if (f_bad_sdo != 0) begin fails++; $display("FAIL frame_sdo_stability: got %0d violations expected 0", f_bad_sdo); end
        tests++;
        if (f_bad_busy != 0) begin fails++; $display("FAIL frame_busy: got %0d violations expected 0", f_bad_busy); end
        tests++;
        if (f_gap != 4) begin fails++; $display("FAIL frame_cs_gap: got %0d expected 4", f_gap); end
        @(negedge clk);
        tests++;
        if ({a_done, a_cs_n, a_busy} !== 3'b010) begin
            fails++; $display("FAIL frame_done_pulse: got done,cs_n,busy=%b expected 010", {a_done, a_cs_n, a_busy});
        end
    endtask

    task automatic test_ignore_start();
        int lows;
        sel = 0;
        @(negedge clk);
        wr = 1'b0; addr = 7'h7F; wdata = 8'h00; start_a = 1'b1;
        capture(10, 50, 100);
        tests++;
        if (f_rise != 16 || f_done_cyc != 140) begin
            fails++; $display("FAIL ignore_one_frame: got rise=%0d done=%0d expected 16/140", f_rise, f_done_cyc);
        end
        tests++;
        if (f_bits !== 16'h7F00) begin fails++; $display("FAIL ignore_bits: got %h expected 7f00", f_bits); end
        lows = 0;
        repeat (40) begin
            @(negedge clk);
            if (a_cs_n !== 1'b1 || a_busy !== 1'b0) lows++;
        end
        tests++;
        if (lows != 0) begin fails++; $display("FAIL ignore_not_queued: got %0d active cycles expected 0", lows); end
    endtask

    task automatic test_back_to_back();
        sel = 0;
        @(negedge clk);
        wr = 1'b1; addr = 7'h03; wdata = 8'hA5; start_a = 1'b1;
        capture(-1, -1, -1);
        tests++;
        if (f_done_cyc != 140 || f_gap != 4) begin
            fails++; $display("FAIL b2b_first: got done=%0d gap=%0d expected 140/4", f_done_cyc, f_gap);
        end
        // Still in the done cycle: request the next frame right away.
        wr = 1'b1; addr = 7'h05; wdata = 8'h3C; start_a = 1'b1;
        capture(-1, -1, -1);
        tests++;
        if (f_cs1 !== 1'b0) begin fails++; $display("FAIL b2b_cs_low_next: got %b expected 0", f_cs1); end
        tests++;
        if (f_bits !== 16'h853C) begin fails++; $display("FAIL b2b_bits: got %h expected 853c", f_bits); end
        tests++;
        if (f_done_cyc != 140 || f_rise != 16) begin
            fails++; $display("FAIL b2b_second: got done=%0d rise=%0d expected 140/16", f_done_cyc, f_rise);
        end
        @(negedge clk);
    endtask

    task automatic test_mid_reset();
        int  n, falls, dones, highs;
        logic ps;
        sel = 0;
        @(negedge clk);
        wr = 1'b1; addr = 7'h03; wdata = 8'hA5; start_a = 1'b1;
        n = 0; falls = 0; ps = a_sclk;
        while (falls < 7 && n < 500) begin
            @(negedge clk);
            start_a = 1'b0;
            n++;
            if (ps && !a_sclk) falls++;
            ps = a_sclk;
        end
        tests++;
        if (falls != 7) begin fails++; $display("FAIL mid_reset_reach: got %0d falls expected 7", falls); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests++;
        if ({a_cs_n, a_sclk, a_sdo, a_busy, a_done} !== 5'b10000) begin
            fails++; $display("FAIL mid_reset_abort: got %b expected 10000", {a_cs_n, a_sclk, a_sdo, a_busy, a_done});
        end
        dones = 0; highs = 0;
        repeat (200) begin
            @(negedge clk);
            if (a_done !== 1'b0) dones++;
            if (a_sclk !== 1'b0 || a_cs_n !== 1'b1) highs++;
        end
        tests++;
        if (dones != 0 || highs != 0) begin
            fails++; $display("FAIL mid_reset_quiet: got done=%0d active=%0d expected 0/0", dones, highs);
        end
        wr = 1'b0; addr = 7'h2A; wdata = 8'h5A; start_a = 1'b1;
        capture(-1, -1, -1);
        tests++;
        if (f_bits !== 16'h2A5A || f_done_cyc != 140 || f_rise != 16) begin
            fails++; $display("FAIL mid_reset_refill: got bits=%h done=%0d rise=%0d expected 2a5a/140/16", f_bits, f_done_cyc, f_rise);
        end
        @(negedge clk);
    endtask

    task automatic test_readback();
        sel = 0;
        do_reset();
        wr = 1'b0; addr = 7'h11; wdata = 8'h22; start_a = 1'b1;
        capture(-1, -1, -1);
        tests++;
        if (f_rd_pre !== 16'h0000) begin fails++; $display("FAIL readback_before_done: got %h expected 0000", f_rd_pre); end
        tests++;
        if (f_rd !== c_RD_EXP) begin fails++; $display("FAIL readback_done: got %h expected %h", f_rd, c_RD_EXP); end
        @(negedge clk);
    endtask

    task automatic test_fast();
        sel = 1;
        @(negedge clk);
        wr = 1'b1; addr = 7'h03; wdata = 8'hA5; start_b = 1'b1;
        capture(-1, -1, -1);
        tests++;
        if (f_done_cyc != 69) begin fails++; $display("FAIL fast_done_cycle: got %0d expected 69", f_done_cyc); end
        tests++;
        if (f_rise1 != 3 || f_rise2 != 7) begin
            fails++; $display("FAIL fast_sclk_period: got rises at %0d,%0d expected 3,7", f_rise1, f_rise2);
        end
        tests++;
        if (f_bits !== 16'h83A5 || f_rise != 16) begin
            fails++; $display("FAIL fast_bits: got %h rise=%0d expected 83a5/16", f_bits, f_rise);
        end
        tests++;
        if (f_gap != 1 || f_bad_sdo != 0 || f_bad_busy != 0) begin
            fails++; $display("FAIL fast_gap_stability: got gap=%0d sdo=%0d busy=%0d expected 1/0/0", f_gap, f_bad_sdo, f_bad_busy);
        end
        tests++;
        if (f_rd !== 16'h0000) begin fails++; $display("FAIL fast_rdata: got %h expected 0000", f_rd); end
        @(negedge clk);
        sel = 0;
    endtask

    initial begin
        sdi = 1'b0; sdi_b = 1'b0;
        test_reset();
        test_frame();
        test_ignore_start();
        test_back_to_back();
        test_mid_reset();
        test_readback();
        test_fast();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
